// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the 4-master round-robin bus arbiter.
// Request/grant signals are active-low; owner indices are 2 bits wide.
package bus_arbiter_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int NUM_MASTERS = 4;
    localparam int BUS_OWNER_W = 2;

    typedef logic [BUS_OWNER_W-1:0] owner_t;

    localparam owner_t BUS_OWNER_MASTER_0 = 2'd0;
    localparam owner_t BUS_OWNER_MASTER_1 = 2'd1;
    localparam owner_t BUS_OWNER_MASTER_2 = 2'd2;
    localparam owner_t BUS_OWNER_MASTER_3 = 2'd3;

    // One-hot (active-high) mask selecting a single master.
    function automatic logic [NUM_MASTERS-1:0] owner_onehot(input owner_t o);
        return 4'b0001 << o;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the masters and the arbiter.
// master: seen from a requester; slave: seen from the arbiter.
interface bus_arbiter_if;
    import bus_arbiter_pkg::*;

    logic   m0_req_, m1_req_, m2_req_, m3_req_;
    logic   m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    owner_t bus_owner;

    modport master (
        output m0_req_, m1_req_, m2_req_, m3_req_,
        input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, bus_owner
    );

    modport slave (
        input  m0_req_, m1_req_, m2_req_, m3_req_,
        output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, bus_owner
    );

endinterface

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin search: first active request in the order
// owner+1, owner+2, owner+3, then the owner itself last.
module bus_arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  owner_t                 owner_i,
    input  logic [NUM_MASTERS-1:0] req_i,     // active-high
    output owner_t                 next_o,
    output logic                   vld_o
);

    // Walk from farthest (the owner itself) to nearest so the nearest wins.
    always_comb begin
        next_o = owner_i;
        vld_o  = 1'b0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            if (req_i[owner_i + owner_t'(i)]) begin
                next_o = owner_i + owner_t'(i);
                vld_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with registered active-low grants.
// The owner keeps the bus while requesting; on release the grant moves to
// the next requester in rotation, or parks on the owner when idle.
// Optional hold-timeout watchdog: define BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    logic [NUM_MASTERS-1:0] req_act;
    owner_t                 owner_q, owner_d;
    logic [NUM_MASTERS-1:0] grnt_q, grnt_d;
    owner_t                 pick_owner;
    logic                   pick_vld;
    logic                   own_req;
    logic                   force_ho;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("bus_arbiter: TIMEOUT_CYCLES must be >= 1");
    end

    assign req_act = {bus.m3_req_ == ENABLE_, bus.m2_req_ == ENABLE_,
                      bus.m1_req_ == ENABLE_, bus.m0_req_ == ENABLE_};
    assign own_req = req_act[owner_q];

    bus_arb_rr_pick u_pick (
        .owner_i (owner_q),
        .req_i   (req_act),
        .next_o  (pick_owner),
        .vld_o   (pick_vld)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic             competing;
    logic             contended;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign competing = |(req_act & ~owner_onehot(owner_q));
    assign contended = own_req && competing;
    assign force_ho  = contended && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Hold counter: runs only while the owner is being contended, clears on
    // any ownership change (which also covers the forced handover).
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if ((owner_d != owner_q) || !contended)
            cnt_d = '0;
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign force_ho = 1'b0;
`endif

    // Next owner: hand over on release (or watchdog), otherwise keep/park.
    always_comb begin
        owner_d = owner_q;
        if ((!own_req || force_ho) && pick_vld)
            owner_d = pick_owner;
        grnt_d = ~owner_onehot(owner_d);
    end

    // Owner and grant registers; reset wins over any handover.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= BUS_OWNER_MASTER_0;
            grnt_q  <= ~owner_onehot(BUS_OWNER_MASTER_0);
        end else begin
            owner_q <= owner_d;
            grnt_q  <= grnt_d;
        end
    end

    assign bus.bus_owner = owner_q;
    assign bus.m0_grnt_  = grnt_q[0];
    assign bus.m1_grnt_  = grnt_q[1];
    assign bus.m2_grnt_  = grnt_q[2];
    assign bus.m3_grnt_  = grnt_q[3];

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes the owner the reference
// model expects after the next edge; a monitor pops and compares after
// every rising edge. Build with BUS_ARB_TIMEOUT_EN to exercise the watchdog.
module tb_bus_arbiter;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 16;
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_arbiter_if bus ();

    bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];

    // Reference state: who owns the bus and how long it has been contended.
    int m_owner = 0;
    int m_cnt   = 0;

    // Drive one cycle of inputs (active-low request vector {m3..m0}),
    // advance the reference model across the coming edge, queue its result.
    task automatic apply(input bit rst, input logic [3:0] req_n);
        bit own, comp, hit, found;
        int nxt, cand;
        reset = rst;
        {bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_} = req_n;
        if (rst) begin
            m_owner = 0;
            m_cnt   = 0;
        end else begin
            own  = (req_n[m_owner] == 1'b0);
            comp = 1'b0;
            for (int j = 0; j < 4; j++)
                if (j != m_owner && req_n[j] == 1'b0) comp = 1'b1;
            hit = TO_EN && own && comp && (m_cnt == TO - 1);
            nxt = m_owner;
            if (!own || hit) begin
                found = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    cand = (m_owner + k) % 4;
                    if (!found && req_n[cand] == 1'b0) begin
                        nxt   = cand;
                        found = 1'b1;
                    end
                end
            end
            if (nxt != m_owner || !(own && comp)) m_cnt = 0;
            else                                  m_cnt = m_cnt + 1;
            m_owner = nxt;
        end
        exp_q.push_back(m_owner);
        @(negedge clk);
    endtask

    // Monitor: one popped expectation per edge, checked away from the edge.
    initial begin
        int e;
        logic [3:0] g, g_exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                g     = {bus.m3_grnt_, bus.m2_grnt_, bus.m1_grnt_, bus.m0_grnt_};
                g_exp = 4'b1111 ^ (4'b0001 << e);
                vectors++;
                if (int'(bus.bus_owner) != e) begin
                    miscompares++;
                    $display("FAIL owner @%0t: got %0d expected %0d", $time, bus.bus_owner, e);
                end
                vectors++;
                if (g !== g_exp) begin
                    miscompares++;
                    $display("FAIL grants @%0t: got %b expected %b", $time, g, g_exp);
                end
                vectors++;
                if ($countones(~g) != 1) begin
                    miscompares++;
                    $display("FAIL one_grant_low @%0t: got %b expected exactly one 0", $time, g);
                end
            end
        end
    end

    // Global time guard.
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, %0d vectors, %0d miscompares",
                 vectors, miscompares);
        $fatal(1);
    end

    initial begin
        logic [3:0] rq;
        // Reset with every master requesting.
        apply(1'b1, 4'b0000);
        apply(1'b1, 4'b0000);
        // Owner 0 releases, only m2 requests -> 2.
        apply(1'b0, 4'b1011);
        // Move to 3, then release with 0..2 all requesting -> wraps to 0.
        apply(1'b0, 4'b0111);
        apply(1'b0, 4'b1000);
        // Park on 1 for 10 idle cycles.
        apply(1'b0, 4'b1101);
        repeat (10) apply(1'b0, 4'b1111);
        // m1 owns, m3 contends for 100 cycles.
        repeat (100) apply(1'b0, 4'b0101);
        // Reach owner 2, contend with m0 for 3 cycles, then reset mid-transfer.
        apply(1'b0, 4'b1011);
        repeat (3) apply(1'b0, 4'b1010);
        apply(1'b1, 4'b1010);
        repeat (6) apply(1'b0, 4'b1010);
        // Newly granted master already withdrawn: m1 gets it, then m2 takes over.
        apply(1'b0, 4'b1101);
        apply(1'b0, 4'b1011);
        apply(1'b0, 4'b1011);
        // Randomized traffic with occasional resets.
        rq = 4'b1111;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) rq = 4'($urandom);
            else                        rq[$urandom_range(3)] = ~rq[$urandom_range(3)];
            apply($urandom_range(63) == 0, rq);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
